// File: rtl/demux1to2_router.sv
// 1-to-2 stream router: one source steered by in_sel into two independent DEPTH-entry FIFOs.
// Optional push statistics (stat_clr, stat0_cnt, stat1_cnt) are built when DEMUX_STATS_EN is defined.
module demux1to2_router #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic [CW-1:0]    out0_count,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CW-1:0]    out1_count
`ifdef DEMUX_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [15:0]      stat0_cnt,
  output logic [15:0]      stat1_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem    [2][DEPTH];
  logic [AW-1:0]    wr_ptr [2];
  logic [AW-1:0]    rd_ptr [2];
  logic [CW-1:0]    count  [2];
  logic             full   [2];
  logic             empty  [2];
  logic             push   [2];
  logic             pop    [2];
  logic             ready  [2];

  always_comb begin
    ready[0] = out0_ready;
    ready[1] = out1_ready;
    for (int unsigned i = 0; i < 2; i++) begin
      full[i]  = (count[i] == CW'(DEPTH));
      empty[i] = (count[i] == '0);
      // Acceptance looks only at the target FIFO's occupancy: a same-cycle pop never frees a slot.
      push[i]  = in_valid & ~full[i] & (in_sel == 1'(i));
      pop[i]   = ~empty[i] & ready[i];
    end
  end

  assign in_ready = ~full[in_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_data;
    end
  end

  // Storage is not reset; gating data by valid gives the zero head after reset.
  assign out0_valid = ~empty[0];
  assign out1_valid = ~empty[1];
  assign out0_data  = empty[0] ? '0 : mem[0][rd_ptr[0]];
  assign out1_data  = empty[1] ? '0 : mem[1][rd_ptr[1]];
  assign out0_count = count[0];
  assign out1_count = count[1];

`ifdef DEMUX_STATS_EN
  logic [15:0] stat_cnt [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) stat_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (stat_clr)     stat_cnt[i] <= '0;
        else if (push[i]) stat_cnt[i] <= stat_cnt[i] + 1'b1;
      end
    end
  end

  assign stat0_cnt = stat_cnt[0];
  assign stat1_cnt = stat_cnt[1];
`endif

endmodule
